if_fetch_stage: RTL and testbench

- Fetch stage directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and runs a single-outstanding request/response handshake to instruction memory. Presents {PC_F, instr_F, valid_F} to IF/ID.
- Applies branch/jump redirects from EX and holds under hazard-unit stall.
- Outputs a NOP bubble whenever no valid instruction is available.

---
 rtl/if_fetch_stage_if.sv | 29 ++
 rtl/if_fetch_stage.sv | 135 +++++++++++++
 tb/tb_if_fetch_stage.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
//   req    : request valid (master -> slave)
//   addr   : 4-aligned byte address of the requested word (master -> slave)
//   gnt    : request accepted this cycle when req & gnt (slave -> master)
//   rvalid : response valid, at least one cycle after acceptance (slave -> master)
//   rdata  : response instruction word (slave -> master)
interface if_fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Fetch stage feeding the IF/ID pipeline register.
// Owns the fetch PC and keeps at most one instruction-memory request in
// flight. Applies EX redirects, holds under hazard stall, and emits a NOP
// bubble whenever it has no valid instruction.
//
// Ports:
//   clk            : clock, all state updates on posedge
//   rst            : asynchronous active-high reset
//   stall_F        : hazard unit hold request (only meaningful in HOLD)
//   redirect_valid : branch taken / jump from EX, beats stall and normal flow
//   redirect_pc    : redirect target, low two bits ignored
//   imem           : instruction-memory bus (master side)
//   PC_F           : address of the instruction on instr_F
//   instr_F        : fetched instruction, NOP_INSTR when valid_F = 0
//   valid_F        : instr_F holds a real instruction
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | first cycle out of reset, no request yet
// FETCH | request for pc_q on the bus, waiting for grant
// WAIT  | request accepted, waiting for its response
// HOLD  | instruction presented to IF/ID, waiting to be consumed
// DROP  | a stale response is still owed; it will be discarded
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall_F,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    if_fetch_stage_if.master         imem,
    output logic [31:0]              PC_F,
    output logic [31:0]              instr_F,
    output logic                     valid_F
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DROP  = 3'd4
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] instr_q;
    logic [31:0] instr_d;
    logic [31:0] redirect_tgt;

    // Masking rather than slicing keeps every redirect_pc bit in use.
    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;

        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                end
            end

            FETCH: begin
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                    // A granted request still owes us a response that must be eaten.
                    state_d = imem.gnt ? DROP : FETCH;
                end else if (imem.gnt) begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = imem.rvalid ? FETCH : DROP;
                end else if (imem.rvalid) begin
                    instr_d = imem.rdata;
                    state_d = HOLD;
                end
            end

            HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = FETCH;
                end else if (!stall_F) begin
                    // Natural 32-bit wrap from FFFF_FFFC to 0000_0000.
                    pc_d    = pc_q + 32'd4;
                    state_d = FETCH;
                end
            end

            DROP: begin
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                end
                if (imem.rvalid) begin
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem.req  = (state_q == FETCH);
    assign imem.addr = pc_q;
    assign PC_F      = pc_q;
    assign valid_F   = (state_q == HOLD);
    assign instr_F   = valid_F ? instr_q : NOP_INSTR;

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        stall_F;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] PC_F;
    logic [31:0] instr_F;
    logic        valid_F;

    logic        gnt_en;
    int          lat;
    logic        pend;
    int          cnt;
    logic [31:0] pend_data;
    logic        prev_valid;

    int          checks;
    int          errors;
    exp_t        exp_q[$];

    if_fetch_stage_if imem ();

    if_fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall_F        (stall_F),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem.master),
        .PC_F           (PC_F),
        .instr_F        (instr_F),
        .valid_F        (valid_F)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0)  return 32'h0050_0093;
        if (a == 32'h10) return 32'hDEAD_BEEF;
        return {a[23:0], 8'h13};
    endfunction

    // Instruction memory: responds 'lat' cycles after acceptance.
    assign imem.gnt = gnt_en;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            imem.rvalid <= 1'b0;
            imem.rdata  <= 32'h0;
            pend        <= 1'b0;
            cnt         <= 0;
            pend_data   <= 32'h0;
        end else begin
            imem.rvalid <= 1'b0;
            if (pend) begin
                if (cnt <= 1) begin
                    imem.rvalid <= 1'b1;
                    imem.rdata  <= pend_data;
                    pend        <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
            if (imem.req && imem.gnt) begin
                if (lat <= 1) begin
                    imem.rvalid <= 1'b1;
                    imem.rdata  <= mem_word(imem.addr);
                end else begin
                    pend      <= 1'b1;
                    cnt       <= lat - 1;
                    pend_data <= mem_word(imem.addr);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer and protocol monitor.
    always @(negedge clk) begin
        if (valid_F && !prev_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_pc", PC_F, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_pc", PC_F, e.pc);
                chk("sb_instr", instr_F, e.instr);
            end
        end
        if (valid_F) begin
            checks++;
            assert (instr_F !== 32'hDEAD_BEEF) else begin
                errors++;
                $error("FAIL stale_data: observed %h expected not DEADBEEF", instr_F);
            end
        end
        if (imem.rvalid) begin
            checks++;
            assert (!(imem.req || valid_F)) else begin
                errors++;
                $error("FAIL rvalid_in_fetch_or_hold: observed req=%b valid=%b expected 0/0", imem.req, valid_F);
            end
        end
        if (imem.req && imem.gnt) begin
            checks++;
            assert (!pend) else begin
                errors++;
                $error("FAIL two_outstanding: observed pend=%b expected 0", pend);
            end
        end
        prev_valid <= valid_F;
    end

    task automatic wait_req(input logic [31:0] a, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!imem.req && n < 50);
        chk({tag, "_timeout"}, 32'(imem.req), 32'd1);
        chk(tag, imem.addr, a);
    endtask

    task automatic expect_req(input logic [31:0] a, input string tag);
        exp_t e;
        wait_req(a, tag);
        e.pc    = a;
        e.instr = mem_word(a);
        exp_q.push_back(e);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid_F && n < 50);
        chk(tag, 32'(valid_F), 32'd1);
    endtask

    task automatic pulse_redirect(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        stall_F        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        gnt_en         = 1'b1;
        lat            = 1;
        prev_valid     = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", 32'(imem.req), 32'd0);
        chk("rst_addr", imem.addr, 32'h0);
        chk("rst_pc", PC_F, 32'h0);
        chk("rst_instr", instr_F, NOP);
        chk("rst_valid", 32'(valid_F), 32'd0);
        rst = 1'b0;

        // Boot: sequential fetch 0, 4, 8
        expect_req(32'h0, "boot_addr0");
        expect_req(32'h4, "boot_addr4");
        expect_req(32'h8, "boot_addr8");

        // Stall hold in HOLD at PC 8
        wait_valid("stall_reach_hold");
        stall_F = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_pc", PC_F, 32'h8);
            chk("stall_instr", instr_F, mem_word(32'h8));
            chk("stall_valid", 32'(valid_F), 32'd1);
            chk("stall_req", 32'(imem.req), 32'd0);
        end
        stall_F = 1'b0;
        expect_req(32'hC, "stall_next_addr");

        // Redirect while WAIT for 0x10 (stale DEADBEEF response)
        wait_valid("c_valid");
        lat = 3;
        wait_req(32'h10, "wait_addr10");
        @(negedge clk);
        chk("wait_state", 32'(dut.state_q), 32'd2);
        pulse_redirect(32'h0000_0203);
        chk("drop_state", 32'(dut.state_q), 32'd4);
        chk("drop_pc", PC_F, 32'h200);
        chk("drop_req", 32'(imem.req), 32'd0);
        lat = 1;
        expect_req(32'h200, "redir_addr200");

        // Redirect beats stall in HOLD
        wait_valid("h200_valid");
        stall_F = 1'b1;
        pulse_redirect(32'h40);
        stall_F = 1'b0;
        chk("rvs_valid", 32'(valid_F), 32'd0);
        chk("rvs_instr", instr_F, NOP);
        chk("rvs_req", 32'(imem.req), 32'd1);
        chk("rvs_addr", imem.addr, 32'h40);
        e.pc    = 32'h40;
        e.instr = mem_word(32'h40);
        exp_q.push_back(e);

        // Back-pressure at 0x14
        wait_valid("h40_valid");
        gnt_en = 1'b0;
        pulse_redirect(32'h14);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_req", 32'(imem.req), 32'd1);
            chk("bp_addr", imem.addr, 32'h14);
            chk("bp_valid", 32'(valid_F), 32'd0);
            chk("bp_instr", instr_F, NOP);
        end
        gnt_en  = 1'b1;
        e.pc    = 32'h14;
        e.instr = mem_word(32'h14);
        exp_q.push_back(e);

        // PC wrap
        wait_valid("h14_valid");
        pulse_redirect(32'hFFFF_FFFC);
        expect_req(32'hFFFF_FFFC, "wrap_addr_top");
        expect_req(32'h0, "wrap_addr_zero");

        // Async reset in WAIT at PC 4
        wait_valid("h0_valid");
        lat = 3;
        wait_req(32'h4, "ar_addr4");
        @(posedge clk);
        #1;
        chk("ar_wait_state", 32'(dut.state_q), 32'd2);
        chk("ar_wait_pc", PC_F, 32'h4);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_pc", PC_F, 32'h0);
        chk("ar_valid", 32'(valid_F), 32'd0);
        chk("ar_instr", instr_F, NOP);
        chk("ar_req", 32'(imem.req), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        lat = 1;
        expect_req(32'h0, "reboot_addr0");
        wait_valid("reboot_valid");
        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
